// File: rtl/adsr_pkg.sv
// Shared state codes, widths and step helper for the ADSR envelope generator.
// Optional build macro ADSR_EXP_EN selects exponential decay/release steps.
package adsr_pkg;

    localparam int ACC_W = 16;
    localparam int ENV_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

`ifdef ADSR_EXP_EN
    // Step proportional to the current level; never 0 unless the rate itself is 0.
    function automatic logic [ACC_W-1:0] exp_step(input logic [7:0] inc,
                                                  input logic [ENV_W-1:0] lvl);
        logic [15:0] prod;
        logic [ACC_W-1:0] step;
        prod = 16'(inc) * 16'(lvl);
        step = {8'h00, prod[15:8]};
        if ((inc != 8'h00) && (prod[15:8] == 8'h00)) begin
            step = 16'h0001;
        end
        return step;
    endfunction
`endif

endpackage

// File: rtl/adsr_tick_gen.sv
// Envelope-rate prescaler: one-cycle tick every PRESCALE clocks.
module adsr_tick_gen #(
    parameter int PRESCALE   = 256,
    parameter int PRESCALE_W = 8
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + PRESCALE_W'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope generator: gate edge detect, phase FSM and 16-bit accumulator.
// Define ADSR_EXP_EN for exponential decay/release steps (linear otherwise).
module adsr_env
    import adsr_pkg::*;
#(
    parameter int PRESCALE   = 256,
    parameter int PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic [7:0]       adsr_ai,
    input  logic [7:0]       adsr_di,
    input  logic [7:0]       adsr_s,
    input  logic [7:0]       adsr_ri,
    output logic [ENV_W-1:0] env,
    output logic             env_active,
    output logic [2:0]       env_state
);

    logic tick;

    adsr_tick_gen #(
        .PRESCALE  (PRESCALE),
        .PRESCALE_W(PRESCALE_W)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    adsr_state_e      state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             gate_q, gate_d;

    logic             rise, fall;
    logic [ACC_W-1:0] target;
    logic [ACC_W-1:0] dec_step, rel_step;
    logic [ACC_W:0]   att_sum, dec_diff;

`ifdef ADSR_EXP_EN
    assign dec_step = exp_step(adsr_di, acc_q[15:8]);
    assign rel_step = exp_step(adsr_ri, acc_q[15:8]);
`else
    assign dec_step = {8'h00, adsr_di};
    assign rel_step = {8'h00, adsr_ri};
`endif

    assign rise     = trig & ~gate_q;
    assign fall     = ~trig & gate_q;
    assign target   = {adsr_s, 8'h00};
    assign att_sum  = {1'b0, acc_q} + {9'h000, adsr_ai};
    assign dec_diff = {1'b0, acc_q} - {1'b0, dec_step};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        gate_d  = trig;
        // A gate edge takes priority over the tick: phase change only, level kept.
        if (rise || fall) begin
            if (rise && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
                state_d = ST_ATTACK;
            end
            if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                         state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end
        end else if (tick) begin
            case (state_q)
                ST_ATTACK: begin
                    if (att_sum[16] || (att_sum[15:0] == 16'hFFFF)) begin
                        acc_d   = 16'hFFFF;
                        state_d = ST_DECAY;
                    end else begin
                        acc_d = att_sum[15:0];
                    end
                end
                ST_DECAY: begin
                    if (dec_diff[16] || (dec_diff[15:0] <= target)) begin
                        acc_d   = target;
                        state_d = ST_SUSTAIN;
                    end else begin
                        acc_d = dec_diff[15:0];
                    end
                end
                ST_SUSTAIN: acc_d = target;
                ST_RELEASE: begin
                    if (acc_q <= rel_step) begin
                        acc_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acc_d = acc_q - rel_step;
                    end
                end
                default: acc_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            gate_q  <= gate_d;
        end
    end

    assign env        = acc_q[15:8];
    assign env_active = (state_q != ST_IDLE);
    assign env_state  = state_q;

endmodule

// File: tb/tb_adsr_env.sv
// Bench for adsr_env (default linear build): PRESCALE=1 and PRESCALE=4 instances
// share stimulus; an integer envelope model is compared every cycle.
module tb_adsr_env;

    logic       clk = 1'b0;
    logic       rst, trig;
    logic [7:0] ai, di, s, ri;
    logic [7:0] env1, env4;
    logic       act1, act4;
    logic [2:0] st1, st4;

    always #5 clk = ~clk;

    adsr_env #(.PRESCALE(1), .PRESCALE_W(8)) dut (
        .clk(clk), .rst(rst), .trig(trig),
        .adsr_ai(ai), .adsr_di(di), .adsr_s(s), .adsr_ri(ri),
        .env(env1), .env_active(act1), .env_state(st1)
    );

    adsr_env #(.PRESCALE(4), .PRESCALE_W(8)) dut4 (
        .clk(clk), .rst(rst), .trig(trig),
        .adsr_ai(ai), .adsr_di(di), .adsr_s(s), .adsr_ri(ri),
        .env(env4), .env_active(act4), .env_state(st4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Phase numbers: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
    typedef struct packed {
        int   acc;
        int   ph;
        logic gate;
        int   cnt;
    } mdl_t;

    function automatic int mstep(input int inc, input int acc);
`ifdef ADSR_EXP_EN
        int p;
        p = (inc * (acc / 256)) / 256;
        if (inc != 0 && p == 0) p = 1;
        return p;
`else
        return inc;
`endif
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input logic r, input logic t,
                                      input int a, input int d, input int sl,
                                      input int rr, input int p);
        mdl_t n;
        bit   tk;
        int   tgt, stp;
        n   = m;
        tk  = (m.cnt == p - 1);
        tgt = sl * 256;
        if (r) begin
            n.acc = 0; n.ph = 0; n.gate = 1'b0; n.cnt = 0;
            return n;
        end
        n.cnt  = tk ? 0 : m.cnt + 1;
        n.gate = t;
        if (t && !m.gate) begin
            if (m.ph == 0 || m.ph == 4) n.ph = 1;
        end else if (!t && m.gate) begin
            if (m.ph >= 1 && m.ph <= 3) n.ph = 4;
        end else if (tk) begin
            case (m.ph)
                1: begin
                    n.acc = (m.acc + a >= 65535) ? 65535 : m.acc + a;
                    if (n.acc == 65535) n.ph = 2;
                end
                2: begin
                    stp = mstep(d, m.acc);
                    if (m.acc - stp <= tgt) begin n.acc = tgt; n.ph = 3; end
                    else n.acc = m.acc - stp;
                end
                3: n.acc = tgt;
                4: begin
                    stp = mstep(rr, m.acc);
                    if (m.acc <= stp) begin n.acc = 0; n.ph = 0; end
                    else n.acc = m.acc - stp;
                end
                default: n.acc = 0;
            endcase
        end
        return n;
    endfunction

    mdl_t m1 = '0;
    mdl_t m4 = '0;

    always @(posedge clk) begin
        m1 <= mdl_next(m1, rst, trig, int'(ai), int'(di), int'(s), int'(ri), 1);
        m4 <= mdl_next(m4, rst, trig, int'(ai), int'(di), int'(s), int'(ri), 4);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("p1_env",    int'(env1), m1.acc / 256);
            chk("p1_state",  int'(st1),  m1.ph);
            chk("p1_active", int'(act1), int'(m1.ph != 0));
            chk("p4_env",    int'(env4), m4.acc / 256);
            chk("p4_state",  int'(st4),  m4.ph);
            chk("p4_active", int'(act4), int'(m4.ph != 0));
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; trig = 1'b0;
        ai = 8'h80; di = 8'h10; s = 8'h80; ri = 8'hFF;
        tick_n(1);
        cmp_en = 1'b1;
        tick_n(2);
        chk("rst_env",    int'(env1), 0);
        chk("rst_active", int'(act1), 0);
        chk("rst_state",  int'(st1),  0);
        rst = 1'b0;
        tick_n(5);
        chk("idle_hold", int'(st1), 0);

        // Attack from 0, decay to sustain 0x80
        trig = 1'b1;
        tick_n(1);
        chk("atk_enter_state", int'(st1), 1);
        chk("atk_enter_env",   int'(env1), 8'h00);
        tick_n(511);
        chk("atk_511_env",   int'(env1), 8'hFF);
        chk("atk_511_state", int'(st1), 1);
        tick_n(1);
        chk("atk_top_state", int'(st1), 2);
        chk("atk_top_env",   int'(env1), 8'hFF);
        tick_n(2047);
        chk("dec_2047_state", int'(st1), 2);
        chk("dec_2047_env",   int'(env1), 8'h80);
        tick_n(1);
        chk("sus_state",  int'(st1), 3);
        chk("sus_env",    int'(env1), 8'h80);
        chk("sus_active", int'(act1), 1);

        // Release with ri=FF reaches 0 on the 129th tick
        trig = 1'b0;
        tick_n(1);
        chk("rel_enter_state", int'(st1), 4);
        chk("rel_enter_env",   int'(env1), 8'h80);
        tick_n(128);
        chk("rel_128_state", int'(st1), 4);
        chk("rel_128_env",   int'(env1), 8'h00);
        tick_n(1);
        chk("rel_done_state",  int'(st1), 0);
        chk("rel_done_active", int'(act1), 0);

        // Gate drops mid-attack at 0x4000, retrigger at 0x2000
        trig = 1'b1;
        tick_n(1);
        chk("re_atk_state", int'(st1), 1);
        tick_n(128);
        chk("atk4000_env", int'(env1), 8'h40);
        trig = 1'b0; ri = 8'h20;
        tick_n(1);
        chk("mid_rel_state", int'(st1), 4);
        chk("mid_rel_env",   int'(env1), 8'h40);
        tick_n(256);
        chk("rel2000_env",   int'(env1), 8'h20);
        chk("rel2000_state", int'(st1), 4);
        trig = 1'b1;
        tick_n(1);
        chk("retrig_state", int'(st1), 1);
        chk("retrig_env",   int'(env1), 8'h20);
        tick_n(32);
        chk("retrig_3000_env", int'(env1), 8'h30);

        // Mid-phase reset, then PRESCALE=4 timing and edge-on-tick
        rst = 1'b1; ai = 8'hFF;
        tick_n(2);
        chk("midrst_env",   int'(env1), 0);
        chk("midrst_state", int'(st1),  0);
        chk("midrst_p4",    int'(st4),  0);
        rst = 1'b0;
        tick_n(1);
        chk("p4_atk_state", int'(st4), 1);
        chk("p4_atk_env",   int'(env4), 0);
        tick_n(10);
        chk("p4_clk11_env", int'(env4), 1);
        tick_n(1);
        chk("p4_clk12_env", int'(env4), 2);
        tick_n(3);
        trig = 1'b0;
        tick_n(1);
        chk("p4_edge_tick_state", int'(st4), 4);
        chk("p4_edge_tick_env",   int'(env4), 2);
        tick_n(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
